// File: rtl/gpio_bank_arbiter.sv
// Round-robin arbiter granting NREQ requesters access to one GPIO bank:
// masked writes to gpio_out, or waits for a masked pattern on gpio_in with timeout.
module gpio_bank_arbiter #(
  parameter int                 NREQ    = 4,
  parameter int                 WIDTH   = 32,
  parameter int                 TMO_W   = 16,
  parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ-1:0]         req_op,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  input  logic [NREQ*WIDTH-1:0]   req_mask,
  input  logic [NREQ*TMO_W-1:0]   req_tmo,
  output logic [NREQ-1:0]         rsp_valid,
  output logic [NREQ-1:0]         rsp_err,
  input  logic [WIDTH-1:0]        gpio_in,
  output logic [WIDTH-1:0]        gpio_out
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next;

  logic [WIDTH-1:0]   r_gin_meta;
  logic [WIDTH-1:0]   r_gin_s;
  logic [WIDTH-1:0]   r_gpio_out;
  logic [WIDTH-1:0]   r_data;
  logic [WIDTH-1:0]   r_mask;
  logic [TMO_W-1:0]   r_cnt;
  logic [IDX_W-1:0]   r_rr_ptr;
  logic [IDX_W-1:0]   r_owner;
  logic               r_err;

  logic               w_found;
  logic [IDX_W-1:0]   w_win;
  logic               w_win_op;
  logic [WIDTH-1:0]   w_win_data;
  logic [WIDTH-1:0]   w_win_mask;
  logic [TMO_W-1:0]   w_win_tmo;
  logic               w_match;

  // Two-flop synchronizer for the asynchronous pins.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_gin_meta <= '0;
      r_gin_s    <= '0;
    end else begin
      r_gin_meta <= gpio_in;
      r_gin_s    <= r_gin_meta;
    end
  end

  // Winner is the first valid index at or after r_rr_ptr, wrapping at NREQ-1.
  // NOTE: every output of a combinational block is defaulted first so no path infers a latch.
  always_comb begin
    int j;
    j          = 0;
    w_found    = 1'b0;
    w_win      = '0;
    w_win_op   = 1'b0;
    w_win_data = '0;
    w_win_mask = '0;
    w_win_tmo  = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(r_rr_ptr) + k) % NREQ;
      if (!w_found && req_valid[j]) begin
        w_found    = 1'b1;
        w_win      = IDX_W'(j);
        w_win_op   = req_op[j];
        w_win_data = req_data[j*WIDTH +: WIDTH];
        w_win_mask = req_mask[j*WIDTH +: WIDTH];
        w_win_tmo  = req_tmo[j*TMO_W +: TMO_W];
      end
    end
  end

  assign w_match = ((r_gin_s & r_mask) == (r_data & r_mask));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and per-requester handshake/response outputs.
  always_comb begin
    w_next    = r_state;
    req_ready = '0;
    rsp_valid = '0;
    rsp_err   = '0;
    unique case (r_state)
      IDLE: begin
        if (w_found) begin
          req_ready[w_win] = 1'b1;
          w_next           = w_win_op ? WAIT : WR;
        end
      end
      WR: begin
        w_next = RESP;
      end
      WAIT: begin
        if (w_match || (r_cnt == '0)) begin
          w_next = RESP;
        end
      end
      RESP: begin
        rsp_valid[r_owner] = 1'b1;
        rsp_err[r_owner]   = r_err;
        w_next             = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Command latch and datapath; the opcode is carried by the WR/WAIT state itself.
  // NOTE: every register here is reset, since an aborted command must leave nothing behind.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_gpio_out <= RST_VAL;
      r_data     <= '0;
      r_mask     <= '0;
      r_cnt      <= '0;
      r_rr_ptr   <= '0;
      r_owner    <= '0;
      r_err      <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_found) begin
            r_owner <= w_win;
            r_data  <= w_win_data;
            r_mask  <= w_win_mask;
            r_cnt   <= w_win_tmo;
            r_err   <= 1'b0;
          end
        end
        WR: begin
          r_gpio_out <= (r_gpio_out & ~r_mask) | (r_data & r_mask);
        end
        WAIT: begin
          if (w_match) begin
            r_err <= 1'b0;
          end else if (r_cnt == '0) begin
            r_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        RESP: begin
          r_rr_ptr <= (r_owner == IDX_W'(NREQ - 1)) ? '0 : r_owner + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign gpio_out = r_gpio_out;

endmodule

// File: tb/tb_gpio_bank_arbiter.sv
// Self-checking bench for gpio_bank_arbiter: directed scenarios plus randomized
// traffic compared each cycle against a transaction-level reference model.
module tb_gpio_bank_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 32;
  localparam int TMO_W = 16;
  localparam int MAXC  = 16384;

  typedef struct {
    logic             op;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] mask;
    int               tmo;
  } cmd_t;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       req_op = '0;
  logic [NREQ*WIDTH-1:0] req_data = '0;
  logic [NREQ*WIDTH-1:0] req_mask = '0;
  logic [NREQ*TMO_W-1:0] req_tmo = '0;
  logic [NREQ-1:0]       rsp_valid;
  logic [NREQ-1:0]       rsp_err;
  logic [WIDTH-1:0]      gpio_in = '0;
  logic [WIDTH-1:0]      gpio_out;

  gpio_bank_arbiter #(
    .NREQ(NREQ), .WIDTH(WIDTH), .TMO_W(TMO_W), .RST_VAL('0)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_data(req_data), .req_mask(req_mask), .req_tmo(req_tmo),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err),
    .gpio_in(gpio_in), .gpio_out(gpio_out)
  );

  always #5 clk = ~clk;

  int               n_checks = 0;
  int               n_errors = 0;
  int               cyc = 0;
  logic [WIDTH-1:0] hist [MAXC];
  logic [WIDTH-1:0] g_drv = '0;

  cmd_t pend      [NREQ];
  bit   pend_v    [NREQ];
  bit   keep_busy [NREQ];
  bit   rand_mode = 1'b0;

  // Reference model: one transaction at a time, timing derived from the command rules.
  bit               m_busy = 1'b0;
  int               m_owner, m_a, m_resp;
  int               m_ptr = 0;
  bit               m_err;
  cmd_t             m_cmd;
  logic [WIDTH-1:0] m_gpio = '0;

  int obs_grant;
  int grant_who [$];
  int grant_cyc [$];
  int rsp_who   [$];
  int rsp_cyc   [$];
  int rsp_e     [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [WIDTH-1:0] gin_s_at(input int n);
    return (n >= 2) ? hist[n-2] : '0;
  endfunction

  function automatic bit any_pend();
    bit r = 1'b0;
    for (int i = 0; i < NREQ; i++) r |= pend_v[i];
    return r;
  endfunction

  task automatic issue(input int i, input logic op, input logic [WIDTH-1:0] d,
                       input logic [WIDTH-1:0] m, input int tmo);
    pend[i].op   = op;
    pend[i].data = d;
    pend[i].mask = m;
    pend[i].tmo  = tmo;
    pend_v[i]    = 1'b1;
  endtask

  task automatic gen_random();
    logic op;
    for (int i = 0; i < NREQ; i++) begin
      if (!pend_v[i] && $urandom_range(0, 3) == 0) begin
        op = 1'($urandom_range(0, 1));
        if (op) issue(i, 1'b1, $urandom & 32'hF, $urandom & 32'hF, $urandom_range(0, 6));
        else    issue(i, 1'b0, $urandom, $urandom, 0);
      end
    end
    if ($urandom_range(0, 3) == 0) g_drv = (g_drv & ~32'hF) | ($urandom & 32'hF);
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]                 = pend_v[i];
      req_op[i]                    = pend[i].op;
      req_data[i*WIDTH +: WIDTH]   = pend[i].data;
      req_mask[i*WIDTH +: WIDTH]   = pend[i].mask;
      req_tmo[i*TMO_W +: TMO_W]    = TMO_W'(pend[i].tmo);
    end
    gpio_in = g_drv;
  endtask

  // One clock cycle: drive after the rising edge, predict, sample on the falling edge.
  task automatic step();
    logic [NREQ-1:0] exp_rdy, exp_rv, exp_re;
    int win, k, j;
    bit match;
    @(posedge clk);
    #1;
    cyc++;
    if (rand_mode) gen_random();
    for (int i = 0; i < NREQ; i++)
      if (keep_busy[i] && !pend_v[i]) issue(i, 1'b0, $urandom, $urandom, 0);
    drive();
    hist[cyc] = g_drv;
    exp_rdy = '0; exp_rv = '0; exp_re = '0; win = -1;
    if (rst) begin
      if (m_busy) begin
        if (cyc == m_resp) begin
          if (!m_cmd.op) m_gpio = (m_gpio & ~m_cmd.mask) | (m_cmd.data & m_cmd.mask);
          exp_rv[m_owner] = 1'b1;
          exp_re[m_owner] = m_err;
          m_busy = 1'b0;
          m_ptr  = (m_owner + 1) % NREQ;
        end else if (m_resp < 0) begin
          if (!m_cmd.op) begin
            m_resp = cyc + 1;
          end else begin
            k     = cyc - m_a - 1;
            match = ((gin_s_at(cyc) ^ m_cmd.data) & m_cmd.mask) == '0;
            if (match || k >= m_cmd.tmo) begin
              m_resp = cyc + 1;
              m_err  = !match;
            end
          end
        end
      end else begin
        for (int s = 0; s < NREQ; s++) begin
          j = (m_ptr + s) % NREQ;
          if (win < 0 && pend_v[j]) win = j;
        end
        if (win >= 0) begin
          exp_rdy[win] = 1'b1;
          m_busy  = 1'b1;
          m_owner = win;
          m_cmd   = pend[win];
          m_a     = cyc;
          m_resp  = -1;
          m_err   = 1'b0;
        end
      end
    end
    @(negedge clk);
    obs_grant = -1;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i] && req_valid[i]) begin
        obs_grant = i;
        grant_who.push_back(i);
        grant_cyc.push_back(cyc);
      end
      if (rsp_valid[i]) begin
        rsp_who.push_back(i);
        rsp_cyc.push_back(cyc);
        rsp_e.push_back(int'(rsp_err[i]));
      end
    end
    if (rst) begin
      check("req_ready", req_ready, exp_rdy);
      check("rsp_valid", rsp_valid, exp_rv);
      check("rsp_err",   rsp_err,   exp_re);
      check("gpio_out",  gpio_out,  m_gpio);
    end else begin
      check("rst_rsp_valid", rsp_valid, '0);
      check("rst_gpio_out",  gpio_out,  '0);
    end
    if (win >= 0) pend_v[win] = 1'b0;
  endtask

  task automatic wait_grant(input int who, output int a);
    int budget = 50;
    a = -1;
    while (budget > 0 && a < 0) begin
      step();
      if (obs_grant == who) a = cyc;
      budget--;
    end
    check($sformatf("grant_seen_%0d", who), 64'(a >= 0), 64'd1);
  endtask

  task automatic drain();
    int budget = 3000;
    while ((m_busy || any_pend()) && budget > 0) begin
      step();
      budget--;
    end
    check("drain_done", 64'(m_busy || any_pend()), 64'd0);
  endtask

  // Checks the single response produced since the log held n0 entries.
  task automatic check_rsp(input string tag, input int n0, input int a,
                           input int who, input int err, input int lat);
    check({tag, "_count"}, 64'(rsp_who.size() - n0), 64'd1);
    if (rsp_who.size() > n0) begin
      check({tag, "_who"}, 64'(rsp_who[n0]), 64'(who));
      check({tag, "_err"}, 64'(rsp_e[n0]),   64'(err));
      check({tag, "_lat"}, 64'(rsp_cyc[n0] - a), 64'(lat));
    end
  endtask

  initial begin
    int a, n0, g0;
    for (int i = 0; i < NREQ; i++) begin
      pend[i]      = '{op: 1'b0, data: '0, mask: '0, tmo: 0};
      pend_v[i]    = 1'b0;
      keep_busy[i] = 1'b0;
    end
    for (int c = 0; c < MAXC; c++) hist[c] = '0;

    // Power-on reset, released away from the rising edge.
    repeat (3) step();
    #2 rst = 1'b1;
    step();
    check("reset_gpio_out",  gpio_out,  32'h0);
    check("reset_rsp_valid", rsp_valid, '0);

    // Masked write.
    n0 = rsp_who.size();
    issue(0, 1'b0, 32'hFFFF_FFFF, 32'h0000_00F0, 0);
    wait_grant(0, a);
    drain();
    check_rsp("wr", n0, a, 0, 0, 2);
    check("wr_gpio", gpio_out, 32'h0000_00F0);

    // Wait that matches once gpio_in[0] rises 10 cycles after the handshake.
    n0 = rsp_who.size();
    issue(2, 1'b1, 32'h1, 32'h1, 100);
    wait_grant(2, a);
    repeat (9) step();
    g_drv = 32'h1;
    drain();
    check_rsp("wait_match", n0, a, 2, 0, 13);
    check("wait_match_gpio", gpio_out, 32'h0000_00F0);

    // Wait that times out: tmo=5 gives 6 compares.
    g_drv = '0;
    repeat (3) step();
    n0 = rsp_who.size();
    issue(1, 1'b1, 32'h1, 32'h1, 5);
    wait_grant(1, a);
    drain();
    check_rsp("wait_tmo", n0, a, 1, 1, 7);

    // Zero mask: write leaves pins alone, wait matches on the first compare.
    n0 = rsp_who.size();
    issue(3, 1'b0, 32'hDEAD_BEEF, 32'h0, 0);
    wait_grant(3, a);
    drain();
    check_rsp("zm_wr", n0, a, 3, 0, 2);
    check("zm_wr_gpio", gpio_out, 32'h0000_00F0);
    n0 = rsp_who.size();
    issue(0, 1'b1, 32'h1234_5678, 32'h0, 50);
    wait_grant(0, a);
    drain();
    check_rsp("zm_wait", n0, a, 0, 0, 2);

    // Reset in the middle of a long wait: no response, everything cleared at once.
    issue(0, 1'b1, 32'h1, 32'h1, 1000);
    wait_grant(0, a);
    repeat (5) step();
    n0 = rsp_who.size();
    #2 rst = 1'b0;
    #1;
    check("rst_mid_gpio",      gpio_out,  32'h0);
    check("rst_mid_rsp_valid", rsp_valid, '0);
    check("rst_mid_rsp_err",   rsp_err,   '0);
    check("rst_mid_ready",     req_ready, '0);
    m_busy = 1'b0;
    m_ptr  = 0;
    m_gpio = '0;
    repeat (3) step();
    #2 rst = 1'b1;
    for (int c = 0; c < cyc; c++) hist[c] = '0;
    step();
    check("rst_mid_no_rsp", 64'(rsp_who.size() - n0), 64'd0);

    // Lone requester 3 after reset, then all four continuously valid.
    issue(3, 1'b0, 32'h5, 32'hF, 0);
    wait_grant(3, a);
    drain();
    g0 = grant_who.size();
    for (int i = 0; i < NREQ; i++) keep_busy[i] = 1'b1;
    repeat (16) step();
    for (int i = 0; i < NREQ; i++) keep_busy[i] = 1'b0;
    drain();
    check("rr_grants", 64'(grant_who.size() - g0 >= 5), 64'd1);
    if (grant_who.size() - g0 >= 5) begin
      for (int g = 0; g < 5; g++) begin
        check($sformatf("rr_order_%0d", g), 64'(grant_who[g0+g]), 64'(g % NREQ));
        if (g > 0)
          check($sformatf("rr_space_%0d", g), 64'(grant_cyc[g0+g] - grant_cyc[g0+g-1]), 64'd3);
      end
    end

    // Randomized traffic against the model.
    rand_mode = 1'b1;
    repeat (1500) step();
    rand_mode = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
